fm_demod_stream: RTL and testbench

- Streaming, parametrised successor of the single-shot FM demodulator.
- Takes quantized I/Q samples over a valid/ready input and conjugate-multiplies each sample with the previously accepted one.
- Computes the phase difference with the codebase arctan core, scales it by a runtime gain and returns a saturated demod sample over a valid/ready output.
- Sits between the channel-select FIR and the audio decimation filters.

---
 rtl/fm_demod_pkg.sv | 63 ++++++
 rtl/fm_demod_stream_atan.sv | 108 ++++++++++
 rtl/fm_demod_stream.sv | 168 ++++++++++++++++
 tb/tb_fm_demod_stream.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fm_demod_pkg.sv
// Shared types, Q-format constants and fixed-point helpers for the streaming FM demodulator.
package fm_demod_pkg;

  localparam int FRAC_BITS_DEF = 10;
  localparam int ONE           = 1 << FRAC_BITS_DEF;
  localparam int PI_Q          = 3217;

  // Arctan core works internally with a Q16 angle accumulator.
  localparam int ANG_FRAC   = 16;
  localparam int ANG_W      = 24;
  localparam int ATAN_ITERS = 16;
  localparam logic signed [ANG_W-1:0] HALF_PI_ANG = 24'sd102944;

  localparam int DQ_W = 128;
  localparam logic signed [DQ_W-1:0] DQ_ONE = {{(DQ_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MULT  = 3'd1,
    ST_DEQ   = 3'd2,
    ST_ATAN  = 3'd3,
    ST_SCALE = 3'd4,
    ST_OUT   = 3'd5
  } state_e;

  // atan(2**-idx) in Q16 radians
  function automatic logic signed [ANG_W-1:0] atan_step(input logic [4:0] idx);
    logic signed [ANG_W-1:0] v;
    case (idx)
      5'd0:    v = 24'sd51472;
      5'd1:    v = 24'sd30385;
      5'd2:    v = 24'sd16055;
      5'd3:    v = 24'sd8150;
      5'd4:    v = 24'sd4091;
      5'd5:    v = 24'sd2047;
      5'd6:    v = 24'sd1024;
      5'd7:    v = 24'sd512;
      5'd8:    v = 24'sd256;
      5'd9:    v = 24'sd128;
      5'd10:   v = 24'sd64;
      5'd11:   v = 24'sd32;
      5'd12:   v = 24'sd16;
      5'd13:   v = 24'sd8;
      5'd14:   v = 24'sd4;
      5'd15:   v = 24'sd2;
      default: v = 24'sd0;
    endcase
    return v;
  endfunction

  // Signed divide by 2**frac rounding toward zero; callers sign-extend in and truncate out.
  function automatic logic signed [DQ_W-1:0] dequantize(input logic signed [DQ_W-1:0] v,
                                                         input int frac);
    logic signed [DQ_W-1:0] bias;
    if (v < 0) begin
      bias = (DQ_ONE <<< frac) - DQ_ONE;
    end else begin
      bias = '0;
    end
    return (v + bias) >>> frac;
  endfunction

endpackage

// File: rtl/fm_demod_stream_atan.sv
// Iterative CORDIC arctan core: atan2(i_y, i_x) in Q FRAC_BITS radians, one iteration per cycle.
module fm_demod_stream_atan
  import fm_demod_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         i_start,
  input  logic signed [DATA_WIDTH-1:0] i_x,
  input  logic signed [DATA_WIDTH-1:0] i_y,
  output logic                         o_done,
  output logic signed [DATA_WIDTH-1:0] o_angle
);

  // Guard bits keep small input vectors from losing angle precision in the shifts.
  localparam int GUARD = 8;
  localparam int CW    = DATA_WIDTH + 2 + GUARD;
  localparam int SH    = ANG_FRAC - FRAC_BITS;
  localparam logic signed [ANG_W:0] RND = (ANG_W+1)'((1 << SH) >> 1);

  logic signed [CW-1:0]         w_xe, w_ye, w_x0, w_y0, w_xs, w_ys, w_xn, w_yn;
  logic signed [ANG_W-1:0]      w_z0, w_zn, w_step;
  logic signed [ANG_W:0]        w_round;
  logic signed [CW-1:0]         r_cx, r_cy;
  logic signed [ANG_W-1:0]      r_z;
  logic [4:0]                   r_iter;
  logic                         r_busy, r_done;
  logic signed [DATA_WIDTH-1:0] r_angle;

  assign w_xe = CW'(i_x) <<< GUARD;
  assign w_ye = CW'(i_y) <<< GUARD;

  // Fold left-half-plane vectors into the right half plane by a +/-90 degree rotation.
  always_comb begin
    if (i_x[DATA_WIDTH-1]) begin
      if (!i_y[DATA_WIDTH-1]) begin
        w_x0 = w_ye;
        w_y0 = -w_xe;
        w_z0 = HALF_PI_ANG;
      end else begin
        w_x0 = -w_ye;
        w_y0 = w_xe;
        w_z0 = -HALF_PI_ANG;
      end
    end else begin
      w_x0 = w_xe;
      w_y0 = w_ye;
      w_z0 = '0;
    end
  end

  // One vectoring micro-rotation driving y toward zero.
  always_comb begin
    w_xs   = r_cx >>> r_iter;
    w_ys   = r_cy >>> r_iter;
    w_step = atan_step(r_iter);
    if (!r_cy[CW-1]) begin
      w_xn = r_cx + w_ys;
      w_yn = r_cy - w_xs;
      w_zn = r_z + w_step;
    end else begin
      w_xn = r_cx - w_ys;
      w_yn = r_cy + w_xs;
      w_zn = r_z - w_step;
    end
    w_round = ((ANG_W+1)'(w_zn) + RND) >>> SH;
  end

  // Iteration control; done pulses for one cycle with the rounded angle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cx    <= '0;
      r_cy    <= '0;
      r_z     <= '0;
      r_iter  <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_angle <= '0;
    end else if (i_start) begin
      r_cx   <= w_x0;
      r_cy   <= w_y0;
      r_z    <= w_z0;
      r_iter <= 5'd0;
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_cx <= w_xn;
      r_cy <= w_yn;
      r_z  <= w_zn;
      if (r_iter == 5'(ATAN_ITERS - 1)) begin
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_angle <= DATA_WIDTH'(w_round);
      end else begin
        r_iter <= r_iter + 5'd1;
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_done  = r_done;
  assign o_angle = r_angle;

endmodule

// File: rtl/fm_demod_stream.sv
// Streaming FM demodulator: conjugate product with the previous sample, arctan, gain and
// saturate, one sample in flight behind valid/ready handshakes.
module fm_demod_stream
  import fm_demod_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  parameter int SATURATE   = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_x,
  input  logic signed [DATA_WIDTH-1:0] in_y,
  input  logic signed [DATA_WIDTH-1:0] gain,
  input  logic                         clear_hist,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_demod,
  output logic                         out_sat
);

  localparam int W2 = 2 * DATA_WIDTH;
  localparam logic signed [W2-1:0] SAT_MAX = W2'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [W2-1:0] SAT_MIN = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_e                       r_state;
  logic signed [DATA_WIDTH-1:0] r_x, r_y, r_xp, r_yp, r_hx, r_hy, r_gain;
  logic signed [W2-1:0]         r_re, r_im;
  logic                         r_atan_start;
  logic signed [DATA_WIDTH-1:0] r_atan_x, r_atan_y, r_angle;
  logic                         r_in_ready, r_out_valid, r_sat;
  logic signed [DATA_WIDTH-1:0] r_demod;

  logic                         w_accept, w_atan_done, w_sat_flag;
  logic signed [W2-1:0]         w_re, w_im, w_p, w_pq;
  logic signed [DATA_WIDTH-1:0] w_re_q, w_im_q, w_atan_angle, w_sat_val;

  assign w_accept = in_valid & r_in_ready;

  // Conjugate product, dequantize and gain scaling with clamp or wrap.
  always_comb begin
    w_re   = W2'(r_x) * W2'(r_hx) + W2'(r_y) * W2'(r_hy);
    w_im   = W2'(r_y) * W2'(r_hx) - W2'(r_x) * W2'(r_hy);
    w_re_q = DATA_WIDTH'(dequantize(DQ_W'(r_re), FRAC_BITS));
    w_im_q = DATA_WIDTH'(dequantize(DQ_W'(r_im), FRAC_BITS));
    w_p    = W2'(r_gain) * W2'(r_angle);
    w_pq   = W2'(dequantize(DQ_W'(w_p), FRAC_BITS));
    if ((SATURATE != 0) && (w_pq > SAT_MAX)) begin
      w_sat_val  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      w_sat_flag = 1'b1;
    end else if ((SATURATE != 0) && (w_pq < SAT_MIN)) begin
      w_sat_val  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      w_sat_flag = 1'b1;
    end else begin
      w_sat_val  = w_pq[DATA_WIDTH-1:0];
      w_sat_flag = 1'b0;
    end
  end

  // History, FSM and registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_xp         <= '0;
      r_yp         <= '0;
      r_hx         <= '0;
      r_hy         <= '0;
      r_gain       <= '0;
      r_re         <= '0;
      r_im         <= '0;
      r_atan_start <= 1'b0;
      r_atan_x     <= '0;
      r_atan_y     <= '0;
      r_angle      <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_demod      <= '0;
      r_sat        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_xp <= in_x;
        r_yp <= in_y;
      end else if (clear_hist) begin
        r_xp <= '0;
        r_yp <= '0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_x        <= in_x;
            r_y        <= in_y;
            r_gain     <= gain;
            r_hx       <= clear_hist ? '0 : r_xp;
            r_hy       <= clear_hist ? '0 : r_yp;
            r_in_ready <= 1'b0;
            r_state    <= ST_MULT;
          end
        end
        ST_MULT: begin
          r_re    <= w_re;
          r_im    <= w_im;
          r_state <= ST_DEQ;
        end
        ST_DEQ: begin
          // A zero vector has no defined angle, so skip the arctan core entirely.
          if ((w_re_q == '0) && (w_im_q == '0)) begin
            r_angle <= '0;
            r_state <= ST_SCALE;
          end else begin
            r_atan_start <= 1'b1;
            r_atan_x     <= w_re_q;
            r_atan_y     <= w_im_q;
            r_state      <= ST_ATAN;
          end
        end
        ST_ATAN: begin
          r_atan_start <= 1'b0;
          if (w_atan_done) begin
            r_angle <= w_atan_angle;
            r_state <= ST_SCALE;
          end
        end
        ST_SCALE: begin
          r_demod     <= w_sat_val;
          r_sat       <= w_sat_flag;
          r_out_valid <= 1'b1;
          r_state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_atan_start <= 1'b0;
          r_out_valid  <= 1'b0;
          r_in_ready   <= 1'b1;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  fm_demod_stream_atan #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_atan (
    .clock  (clock),
    .reset  (reset),
    .i_start(r_atan_start),
    .i_x    (r_atan_x),
    .i_y    (r_atan_y),
    .o_done (w_atan_done),
    .o_angle(w_atan_angle)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_demod = r_demod;
  assign out_sat   = r_sat;

endmodule

// File: tb/tb_fm_demod_stream.sv
// Directed bench for fm_demod_stream: a vector table plus hand-written handshake and reset sequences.
module tb_fm_demod_stream;
  import fm_demod_pkg::*;

  localparam int W = 32;

  logic clock;
  logic reset;
  logic in_valid, clear_hist, out_ready;
  logic signed [W-1:0] in_x, in_y, gain;
  logic in_ready, out_valid, out_sat;
  logic signed [W-1:0] out_demod;
  logic w_in_ready, w_out_valid, w_sat;
  logic signed [W-1:0] w_demod;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] g;
    logic                clr;
    longint              exp;
    longint              tol;
    logic                byp;
  } vec_t;

  vec_t vecs[11];

  fm_demod_stream #(.DATA_WIDTH(W), .FRAC_BITS(10), .SATURATE(1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .gain(gain), .clear_hist(clear_hist),
    .out_valid(out_valid), .out_ready(out_ready), .out_demod(out_demod), .out_sat(out_sat)
  );

  fm_demod_stream #(.DATA_WIDTH(W), .FRAC_BITS(10), .SATURATE(0)) dut_wrap (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_x(in_x), .in_y(in_y), .gain(gain), .clear_hist(clear_hist),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_demod(w_demod), .out_sat(w_sat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no summary expected summary");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp, input longint tol);
    longint d;
    checks++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic xfer(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                      input logic signed [W-1:0] g, input logic clr,
                      output longint d, output longint s, output longint dw,
                      output longint sw, output int lat);
    int guard;
    @(negedge clock);
    in_x = x; in_y = y; gain = g; clear_hist = clr; in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0; clear_hist = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clock);
      #1;
      lat++;
    end
    d = out_demod; s = out_sat; dw = w_demod; sw = w_sat;
    @(posedge clock);
    #1;
  endtask

  initial begin
    longint d, s, dw, sw;
    int lat, guard, bad;
    longint d0;
    logic signed [W-1:0] e32;
    logic signed [63:0] p64;
    bit found;

    vecs[0]  = '{32'sd1024,  32'sd0,    32'sd1024,  1'b0, 0,              0, 1'b1};
    vecs[1]  = '{32'sd0,     32'sd1024, 32'sd1024,  1'b0, PI_Q / 2,       2, 1'b0};
    vecs[2]  = '{32'sd1024,  32'sd0,    -32'sd1024, 1'b0, PI_Q / 2,       2, 1'b0};
    vecs[3]  = '{-32'sd1024, 32'sd0,    32'sd2048,  1'b0, 2 * PI_Q,       4, 1'b0};
    vecs[4]  = '{-32'sd1024, 32'sd0,    32'sd1024,  1'b0, 0,              2, 1'b0};
    vecs[5]  = '{32'sd724,   32'sd724,  32'sd1024,  1'b0, -2413,          2, 1'b0};
    vecs[6]  = '{32'sd2048,  32'sd0,    32'sd512,   1'b0, -402,           2, 1'b0};
    vecs[7]  = '{32'sd0,     32'sd1024, 32'sd1024,  1'b1, 0,              0, 1'b1};
    vecs[8]  = '{32'sd0,     32'sd0,    32'sd1024,  1'b0, 0,              0, 1'b1};
    vecs[9]  = '{32'sd1,     32'sd0,    32'sd1024,  1'b0, 0,              0, 1'b1};
    vecs[10] = '{-32'sd1,    32'sd3,    32'sd1024,  1'b0, 0,              0, 1'b1};

    reset = 1'b1; in_valid = 1'b0; clear_hist = 1'b0; out_ready = 1'b1;
    in_x = '0; in_y = '0; gain = '0;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", in_ready, 1, 0);
    chk("rst_out_valid", out_valid, 0, 0);
    chk("rst_out_demod", out_demod, 0, 0);
    chk("rst_out_sat", out_sat, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      xfer(vecs[i].x, vecs[i].y, vecs[i].g, vecs[i].clr, d, s, dw, sw, lat);
      chk($sformatf("vec%0d_demod", i), d, vecs[i].exp, vecs[i].tol);
      chk($sformatf("vec%0d_sat", i), s, 0, 0);
      if (vecs[i].byp) chk($sformatf("vec%0d_latency", i), lat, 4, 0);
      else chk($sformatf("vec%0d_done", i), longint'(lat < 200), 1, 0);
    end

    // Saturation versus wrap with maximum gain at +/- pi/2.
    xfer(32'sd1024, 32'sd0, ONE, 1'b1, d, s, dw, sw, lat);
    chk("sat_first_zero", d, 0, 0);
    xfer(32'sd0, 32'sd1024, 32'sh7FFFFFFF, 1'b0, d, s, dw, sw, lat);
    chk("sat_pos_demod", d, 64'sd2147483647, 0);
    chk("sat_pos_flag", s, 1, 0);
    found = 1'b0;
    for (int a = 1605; a <= 1611; a++) begin
      p64 = 64'sd2147483647 * 64'(a);
      e32 = 32'(p64 >>> 10);
      if (longint'(e32) == dw) found = 1'b1;
    end
    chk("wrap_pos_demod_in_set", found, 1, 0);
    chk("wrap_pos_flag", sw, 0, 0);
    xfer(32'sd1024, 32'sd0, 32'sh7FFFFFFF, 1'b0, d, s, dw, sw, lat);
    chk("sat_neg_demod", d, -64'sd2147483648, 0);
    chk("sat_neg_flag", s, 1, 0);

    // Backpressure: hold out_ready low for 10 cycles while a new sample is offered.
    @(negedge clock);
    in_x = 32'sd1024; in_y = 32'sd0; gain = ONE; clear_hist = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clock);
    #1;
    in_valid = 1'b0; clear_hist = 1'b0;
    guard = 0;
    while (!out_valid && guard < 200) begin
      @(posedge clock);
      #1;
      guard++;
    end
    chk("bp_out_valid", out_valid, 1, 0);
    d0 = out_demod;
    chk("bp_demod", d0, 0, 0);
    in_x = -32'sd1024; in_y = 32'sd0; in_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock);
      #1;
      if (!out_valid || longint'(out_demod) != d0 || in_ready) bad++;
    end
    chk("bp_hold_unstable_cycles", bad, 0, 0);
    in_valid = 1'b0;
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("bp_release_in_ready", in_ready, 1, 0);
    chk("bp_release_out_valid", out_valid, 0, 0);
    xfer(32'sd0, 32'sd1024, ONE, 1'b0, d, s, dw, sw, lat);
    chk("bp_not_accepted", d, PI_Q / 2, 2);

    // clear_hist pulsed while idle between two samples.
    xfer(32'sd1024, 32'sd0, ONE, 1'b0, d, s, dw, sw, lat);
    chk("clr_pre_demod", d, -(PI_Q / 2), 2);
    @(negedge clock);
    clear_hist = 1'b1;
    @(negedge clock);
    clear_hist = 1'b0;
    xfer(32'sd0, 32'sd1024, ONE, 1'b0, d, s, dw, sw, lat);
    chk("clr_demod", d, 0, 0);
    chk("clr_latency", lat, 4, 0);

    // Asynchronous reset while the arctan core is iterating.
    xfer(32'sd1024, 32'sd0, ONE, 1'b0, d, s, dw, sw, lat);
    chk("arst_pre_demod", d, -(PI_Q / 2), 2);
    @(negedge clock);
    in_x = 32'sd0; in_y = 32'sd1024; gain = ONE; in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    chk("arst_busy_in_ready", in_ready, 0, 0);
    reset = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1, 0);
    chk("arst_out_valid", out_valid, 0, 0);
    chk("arst_out_demod", out_demod, 0, 0);
    chk("arst_out_sat", out_sat, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    xfer(32'sd0, 32'sd1024, ONE, 1'b0, d, s, dw, sw, lat);
    chk("arst_next_demod", d, 0, 0);
    chk("arst_next_latency", lat, 4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
